lfsr5_gen: RTL and testbench
============================

Name: lfsr5_gen

Overview:
- Free-running Fibonacci linear-feedback shift register; default configuration is a 5-bit maximal-length sequence (polynomial x^5 + x^3 + 1, period 31).
- Used as a pseudo-random pattern source or sequence counter; no enable, it steps every clock.
- Exposes the full state vector plus a one-cycle wrap indication each time the sequence returns to its seed.

Parameters:
- WIDTH, 5, state/output width in bits (at least 2).
- TAPS, 5'b10100, feedback tap mask of WIDTH bits; bit i set means q[i] is XORed into feedback. The default selects q[4] and q[2].
- SEED, 5'b00001, WIDTH-bit state loaded on reset; must be nonzero for normal operation.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- q  output  WIDTH  current LFSR state (registered).
- wrap  output  1  registered pulse; high in a cycle where q has just returned to SEED by shifting, not by reset.

Behaviour:
- Single clock domain. All state changes on the rising edge of clk. No asynchronous paths.
- Reset: on any clk edge with reset=1, q <= SEED and wrap <= 0. Held reset keeps q=SEED and wrap=0. Reset has priority over stepping.
- Step, on each edge with reset=0:
  - fb = XOR-reduce(q & TAPS).
  - q <= {q[WIDTH-2:0], fb}, i.e. shift left with fb entering bit 0.
- Default sequence from reset, hex: 01, 02, 04, 09, 12, 05, 0B, 16, 0C, 19, 13, ... This has period 31 and visits every nonzero 5-bit value exactly once.
- wrap <= 1 when reset=0 and the next q equals SEED; otherwise wrap <= 0.
  - Default config: wrap is first high for the one cycle after the 31st post-reset edge, then every 31 cycles.
- Latency: q changes one cycle after the edge that samples reset low. There is no pipeline.
- Reset mid-sequence: the next edge restores SEED regardless of the current state. Stepping resumes on the first edge with reset=0.
- All-zero state, reachable only if SEED=0: without the optional feature, q stays all-zero forever.
- Output q is driven directly from the state register (glitch-free).

Optional Feature:
- Macro LFSR_LOCKUP_GUARD_EN.
- When defined:
  - If q is all zeros and reset=0, the next state is forced to 1 (only the LSB set) instead of the shifted value.
  - wrap is evaluated on that forced next state.
- When undefined: no guard logic is present, and the all-zero state is self-sustaining.
- Reset behaviour is identical in both builds.

Test Plan:
- Hold reset=1 for 2 edges, then release -> q=5'h01 and wrap=0 while in reset; after the next 8 edges q steps through 02, 04, 09, 12, 05, 0B, 16, 0C.
- Run 31 edges after reset release -> q=5'h01 again; wrap=1 for exactly that one cycle; no other value repeats within the 31 states; 5'h00 never appears.
- Run 62 edges -> wrap pulses exactly twice, 31 cycles apart, each one cycle wide.
- Assert reset for 1 edge while q=5'h16 -> next q=5'h01, wrap=0; the following edge gives q=5'h02.
- SEED=0 override, LFSR_LOCKUP_GUARD_EN undefined -> q remains 00 for 10 edges and wrap stays 0.
- SEED=0 override, LFSR_LOCKUP_GUARD_EN defined -> the first post-reset edge gives q=01, followed by 02, 04, 09.

Source files
------------

// File: rtl/lfsr5_gen.sv
// lfsr5_gen: free-running Fibonacci LFSR, shifts left with feedback into bit 0.
// Default: 5-bit maximal sequence x^5 + x^3 + 1 (taps q[4], q[2]), period 31.
//
// Parameters:
//   WIDTH - state width in bits (>= 2)
//   TAPS  - feedback tap mask; bit i set XORs q[i] into the feedback
//   SEED  - state loaded on reset (nonzero for normal operation)
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high reset (priority over stepping)
//   q     - current LFSR state, straight from the state register
//   wrap  - registered one-cycle pulse when q has just stepped back to SEED
//
// Optional build macro: LFSR_LOCKUP_GUARD_EN
//   When defined, an all-zero state steps to 1 instead of locking up.

module lfsr5_gen #(
    parameter int               WIDTH = 5,
    parameter logic [WIDTH-1:0] TAPS  = 5'b10100,
    parameter logic [WIDTH-1:0] SEED  = 5'b00001
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] q,
    output logic             wrap
);

    logic             fb;
    logic [WIDTH-1:0] next_q;
    logic             next_wrap;

    always_comb begin
        fb     = ^(q & TAPS);
        next_q = {q[WIDTH-2:0], fb};
`ifdef LFSR_LOCKUP_GUARD_EN
        if (q == '0) begin
            next_q = {{(WIDTH-1){1'b0}}, 1'b1};
        end
`endif
        // A state that maps onto itself (e.g. all-zero with SEED=0) never
        // "returns" to the seed, so wrap also requires the state to move.
        next_wrap = (next_q == SEED) && (next_q != q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q    <= SEED;
            wrap <= 1'b0;
        end else begin
            q    <= next_q;
            wrap <= next_wrap;
        end
    end

endmodule

// File: tb/tb_lfsr5_gen.sv
// tb_lfsr5_gen: self-checking bench for lfsr5_gen.
// Vector table, sequence corner cases, random resets against a position model.

module tb_lfsr5_gen;

    logic       clk;
    logic       reset;
    logic       reset1;
    logic [4:0] q;
    logic       wrap;
    logic [4:0] q1;
    logic       wrap1;

    int checks = 0;
    int errors = 0;

    lfsr5_gen u_dut (
        .clk  (clk),
        .reset(reset),
        .q    (q),
        .wrap (wrap)
    );

    lfsr5_gen #(
        .WIDTH(5),
        .TAPS (5'b10100),
        .SEED (5'b00000)
    ) u_zero (
        .clk  (clk),
        .reset(reset1),
        .q    (q1),
        .wrap (wrap1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [4:0] exp_q;
        logic       exp_wrap;
    } vec_t;

    vec_t vecs[15];

    // Reference: the sequence as a table of 31 states, position tracked by
    // an index that resets to 0 and advances modulo 31.
    logic [4:0] seq[31];
    int         idx;
    logic       m_wrap;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input logic r);
        reset = r;
        @(posedge clk);
        #1;
        if (r) begin
            idx    = 0;
            m_wrap = 1'b0;
        end else begin
            idx    = (idx + 1) % 31;
            m_wrap = (idx == 0);
        end
    endtask

    task automatic check_model(input string name);
        check({name, "_q"}, int'(q), int'(seq[idx]));
        check({name, "_wrap"}, int'(wrap), int'(m_wrap));
    endtask

    initial begin
        int         s;
        int         wraps;
        int         first_wrap;
        int         last_wrap;
        bit         seen[32];
        logic       r;

        reset  = 1'b1;
        reset1 = 1'b1;
        idx    = 0;
        m_wrap = 1'b0;

        // Build the state table by counting parity of tapped bits.
        s = 1;
        for (int i = 0; i < 31; i++) begin
            seq[i] = s[4:0];
            s = ((s * 2) + ($countones(s & 'h14) % 2)) % 32;
        end

        vecs[0]  = '{1'b1, 5'h01, 1'b0};
        vecs[1]  = '{1'b1, 5'h01, 1'b0};
        vecs[2]  = '{1'b0, 5'h02, 1'b0};
        vecs[3]  = '{1'b0, 5'h04, 1'b0};
        vecs[4]  = '{1'b0, 5'h09, 1'b0};
        vecs[5]  = '{1'b0, 5'h12, 1'b0};
        vecs[6]  = '{1'b0, 5'h05, 1'b0};
        vecs[7]  = '{1'b0, 5'h0B, 1'b0};
        vecs[8]  = '{1'b0, 5'h16, 1'b0};
        vecs[9]  = '{1'b0, 5'h0C, 1'b0};
        vecs[10] = '{1'b0, 5'h19, 1'b0};
        vecs[11] = '{1'b0, 5'h13, 1'b0};
        vecs[12] = '{1'b0, 5'h07, 1'b0};
        vecs[13] = '{1'b1, 5'h01, 1'b0};
        vecs[14] = '{1'b0, 5'h02, 1'b0};

        for (int i = 0; i < 15; i++) begin
            tick(vecs[i].rst);
            check($sformatf("vec%0d_q", i), int'(q), int'(vecs[i].exp_q));
            check($sformatf("vec%0d_wrap", i), int'(wrap),
                  int'(vecs[i].exp_wrap));
        end

        // Full period: unique nonzero states, wrap only on the 31st edge.
        tick(1'b1);
        tick(1'b1);
        check("rst_hold_q", int'(q), 'h01);
        check("rst_hold_wrap", int'(wrap), 0);
        for (int i = 0; i < 32; i++) seen[i] = 1'b0;
        seen[1] = 1'b1;
        wraps = 0;
        for (int e = 1; e <= 31; e++) begin
            tick(1'b0);
            if (e < 31) begin
                check($sformatf("uniq_e%0d", e), int'(seen[q]), 0);
                check($sformatf("nonzero_e%0d", e), int'(q != 5'h00), 1);
                seen[q] = 1'b1;
            end
            if (wrap) wraps++;
        end
        check("period_q", int'(q), 'h01);
        check("period_wrap", int'(wrap), 1);
        check("period_wrap_count", wraps, 1);

        // Two periods: exactly two one-cycle pulses, 31 cycles apart.
        tick(1'b1);
        wraps      = 0;
        first_wrap = -1;
        last_wrap  = -1;
        for (int e = 1; e <= 62; e++) begin
            tick(1'b0);
            check_model("two_per");
            if (wrap) begin
                wraps++;
                if (first_wrap < 0) first_wrap = e;
                last_wrap = e;
            end
        end
        check("two_per_count", wraps, 2);
        check("two_per_first", first_wrap, 31);
        check("two_per_gap", last_wrap - first_wrap, 31);

        // Reset mid-sequence while q = 16.
        tick(1'b1);
        for (int e = 0; e < 7; e++) tick(1'b0);
        check("mid_pre_q", int'(q), 'h16);
        tick(1'b1);
        check("mid_rst_q", int'(q), 'h01);
        check("mid_rst_wrap", int'(wrap), 0);
        tick(1'b0);
        check("mid_post_q", int'(q), 'h02);

        // Random reset pulses against the position model.
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 19) == 0);
            tick(r);
            check_model($sformatf("rnd%0d", i));
        end

        // SEED = 0 instance.
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("zero_rst_q", int'(q1), 'h00);
        check("zero_rst_wrap", int'(wrap1), 0);
        reset1 = 1'b0;
`ifdef LFSR_LOCKUP_GUARD_EN
        begin
            logic [4:0] gexp[4];
            gexp[0] = 5'h01;
            gexp[1] = 5'h02;
            gexp[2] = 5'h04;
            gexp[3] = 5'h09;
            for (int e = 0; e < 4; e++) begin
                @(posedge clk);
                #1;
                check($sformatf("guard_q%0d", e), int'(q1), int'(gexp[e]));
                check($sformatf("guard_wrap%0d", e), int'(wrap1), 0);
            end
        end
`else
        for (int e = 0; e < 10; e++) begin
            @(posedge clk);
            #1;
            check($sformatf("lock_q%0d", e), int'(q1), 'h00);
            check($sformatf("lock_wrap%0d", e), int'(wrap1), 0);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
